instruction_decoder: RTL

//  Assembles variable-length instructions from the 64-bit fetch word stream into

---
 rtl/instruction_decoder_pkg.sv | 65 ++++++
 rtl/instruction_decoder_arg_size_truncate.sv | 22 ++
 rtl/instruction_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instruction_decoder_pkg.sv
// Shared instruction format for the fetch/decode/execute path: header field
// positions, opcode and operand-size encodings, decoder states.
package instruction_decoder_pkg;

  localparam int WORD_W       = 64;
  localparam int NUM_ARGS     = 4;
  localparam int OPCODE_LSB   = 0;
  localparam int OPCODE_W     = 16;
  localparam int ARG_SIZE_LSB = 16;
  localparam int ARG_SIZE_W   = 4;
  localparam int FLAGS_LSB    = 32;
  localparam int FLAGS_W      = 8;
  localparam int REG_IDX_LSB  = 40;
  localparam int REG_IDX_W    = 4;
  localparam int RESERVED_LSB = 56;
  localparam int RESERVED_W   = 8;

  typedef enum logic [15:0] {
    NOP    = 16'd0,
    MOVE   = 16'd1,
    ADD    = 16'd2,
    SUB    = 16'd3,
    MUL    = 16'd4,
    CMP    = 16'd5,
    JMP    = 16'd6,
    JZ     = 16'd7,
    LOAD   = 16'd8,
    STORE  = 16'd9,
    SETF   = 16'd10,
    CLEARF = 16'd11
  } opcode_t;

  localparam logic [15:0] OPCODE_MAX = CLEARF;

  typedef enum logic [3:0] {
    BITS_8  = 4'd0,
    BITS_16 = 4'd1,
    BITS_32 = 4'd2,
    BITS_64 = 4'd3
  } size_flags_t;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    IMM    = 2'd1,
    DONE   = 2'd2
  } decoder_state_t;

  // Flags [3:0] mark which args are carried as trailing immediate words.
  typedef struct packed {
    logic [15:0]           opcode;
    logic [3:0][3:0]       arg_size;
    logic [7:0]            flags;
    logic [3:0][63:0]      arg;
  } instruction_t;

  localparam int INSTR_W = $bits(instruction_t);

  function automatic logic [2:0] instr_len(input logic [3:0] imm_mask);
    int cnt;
    cnt = 1;
    for (int n = 0; n < NUM_ARGS; n++) cnt += int'(imm_mask[n]);
    return 3'(cnt);
  endfunction

endpackage

// File: rtl/instruction_decoder_arg_size_truncate.sv
// Masks a 64-bit operand down to its declared size, zero-extended.
// Shared with the execute stage, so it stays purely combinational.
module arg_size_truncate
  import instruction_decoder_pkg::*;
(
  input  logic [3:0]  size,
  input  logic [63:0] value,
  output logic [63:0] truncated
);

  always_comb begin
    truncated = '0;
    case (size_flags_t'(size))
      BITS_8:  truncated = {56'd0, value[7:0]};
      BITS_16: truncated = {48'd0, value[15:0]};
      BITS_32: truncated = {32'd0, value[31:0]};
      BITS_64: truncated = value;
      default: truncated = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decoder.sv
// Assembles variable-length instructions (header + 0..4 immediate words)
// from the fetch word stream and hands them to execute.
//
// state  | meaning
// HEADER | waiting for the header word of the next instruction
// IMM    | header latched, collecting immediates for the pending mask
// DONE   | instruction complete, out_valid high until execute takes it
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int REG_IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_illegal,
  output logic [2:0]         out_len
);

  decoder_state_t state_q;
  instruction_t   instr_q;
  instruction_t   hdr;
  logic           hdr_illegal;
  logic           illegal_q;
  logic [2:0]     len_q;
  logic [3:0]     mask_q;
  logic [3:0]     mask_rest;
  logic [1:0]     imm_idx;
  logic [63:0]    imm_value;
  logic           out_valid_q;
  logic           take_hdr;

  always_comb begin
    hdr         = '0;
    hdr.opcode  = in_word[OPCODE_LSB +: OPCODE_W];
    hdr.flags   = in_word[FLAGS_LSB +: FLAGS_W];
    hdr_illegal = (in_word[OPCODE_LSB +: OPCODE_W] > OPCODE_MAX) ||
                  (in_word[RESERVED_LSB +: RESERVED_W] != '0);
    for (int n = 0; n < NUM_ARGS; n++) begin
      hdr.arg_size[n] = in_word[ARG_SIZE_LSB + n*ARG_SIZE_W +: ARG_SIZE_W];
      if (in_word[ARG_SIZE_LSB + n*ARG_SIZE_W +: ARG_SIZE_W] > BITS_64) hdr_illegal = 1'b1;
    end
    // Illegal instructions report zero args; immediates are still swallowed.
    for (int n = 0; n < NUM_ARGS; n++) begin
      if (!hdr_illegal && !hdr.flags[n])
        hdr.arg[n] = {{(64-REG_IDX_W){1'b0}}, in_word[REG_IDX_LSB + n*REG_IDX_W +: REG_IDX_W]};
    end
  end

  always_comb begin
    imm_idx = 2'd0;
    for (int n = NUM_ARGS-1; n >= 0; n--) begin
      if (mask_q[n]) imm_idx = 2'(n);
    end
  end

  assign mask_rest = mask_q & ~(4'b0001 << imm_idx);

  arg_size_truncate u_trunc (
    .size      (instr_q.arg_size[imm_idx]),
    .value     (in_word[63:0]),
    .truncated (imm_value)
  );

  // Retiring in DONE and taking the next header share one cycle.
  assign take_hdr = in_valid && (state_q == HEADER || (state_q == DONE && out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HEADER;
      instr_q     <= '0;
      illegal_q   <= 1'b0;
      len_q       <= 3'd0;
      mask_q      <= 4'd0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= HEADER;
      instr_q     <= '0;
      illegal_q   <= 1'b0;
      len_q       <= 3'd0;
      mask_q      <= 4'd0;
      out_valid_q <= 1'b0;
    end else if (take_hdr) begin
      instr_q   <= hdr;
      illegal_q <= hdr_illegal;
      len_q     <= instr_len(hdr.flags[3:0]);
      mask_q    <= hdr.flags[3:0];
      if (hdr.flags[3:0] == 4'd0) begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
      end else begin
        state_q     <= IMM;
        out_valid_q <= 1'b0;
      end
    end else if (state_q == IMM && in_valid) begin
      if (!illegal_q) instr_q.arg[imm_idx] <= imm_value;
      mask_q <= mask_rest;
      if (mask_rest == 4'd0) begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
      end
    end else if (state_q == DONE && out_ready) begin
      state_q     <= HEADER;
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready    = rst_n && !flush && (state_q != DONE || out_ready);
  assign out_valid   = out_valid_q;
  assign out_instr   = instr_q;
  assign out_illegal = illegal_q;
  assign out_len     = len_q;

endmodule
